// File: rtl/instruction_fetch_responder_pkg.sv
// Shared constants and the fetch fault check for the instruction fetch responder.
package instruction_fetch_responder_pkg;

  localparam int unsigned DEFAULT_DEPTH = 256;
  localparam logic [31:0] NOP_WORD_C    = 32'h0000_0013;

  // Fault on a misaligned PC or a PC at/after the end of the array; a 34-bit compare avoids wrap.
  function automatic logic fetch_fault(input logic [31:0] addr, input int unsigned depth);
    logic [33:0] limit;
    limit = 34'(depth) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/instruction_rom_array.sv
// Instruction storage: one synchronous write port, one combinational read port, no reset.
module instruction_rom_array #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [31:0]              i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [31:0]              o_rdata
);

  logic [31:0] r_mem [DEPTH];

  // Program-load write; contents persist across reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read is sampled by the response register on the same edge as a write, so it sees old data.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch_responder.sv
// Single-cycle instruction fetch responder with a one-entry response register.
module instruction_fetch_responder
  import instruction_fetch_responder_pkg::*;
#(
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] NOP_WORD = NOP_WORD_C
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     reqValid,
  output logic                     reqReady,
  input  logic [31:0]              reqAddr,
  output logic                     rspValid,
  input  logic                     rspReady,
  output logic [31:0]              rspInstr,
  output logic [31:0]              rspAddr,
  output logic                     rspFault,
  input  logic                     loadEnable,
  input  logic [$clog2(DEPTH)-1:0] loadAddr,
  input  logic [31:0]              loadData
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [31:0]   r_instr;
  logic [31:0]   r_addr;
  logic          r_fault;
  logic          w_accept;
  logic          w_fault;
  logic [AW-1:0] w_index;
  logic [31:0]   w_rdata;
  logic [31:0]   w_instr;

  assign reqReady = (r_state == S_EMPTY) || rspReady;
  assign w_accept = reqValid && reqReady;
  assign w_fault  = fetch_fault(reqAddr, DEPTH);
  // A faulting address never reaches the array index.
  assign w_index  = w_fault ? '0 : reqAddr[AW+1:2];
  assign w_instr  = w_fault ? NOP_WORD : w_rdata;

  instruction_rom_array #(
    .DEPTH (DEPTH)
  ) u_rom (
    .i_clk   (clock),
    .i_we    (loadEnable),
    .i_waddr (loadAddr),
    .i_wdata (loadData),
    .i_raddr (w_index),
    .o_rdata (w_rdata)
  );

  // Response register occupancy state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: fill on accept, drain when consumed with no new accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (rspReady && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Response payload captured on accept, held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_instr <= '0;
      r_addr  <= '0;
      r_fault <= 1'b0;
    end else if (w_accept) begin
      r_instr <= w_instr;
      r_addr  <= reqAddr;
      r_fault <= w_fault;
    end
  end

  assign rspValid = (r_state == S_FULL);
  assign rspInstr = r_instr;
  assign rspAddr  = r_addr;
  assign rspFault = r_fault;

endmodule

// File: tb/tb_instruction_fetch_responder.sv
// Directed scoreboard bench for instruction_fetch_responder (DEPTH=256).
module tb_instruction_fetch_responder;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        fault;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic [31:0] reqAddr;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspInstr;
  logic [31:0] rspAddr;
  logic        rspFault;
  logic        loadEnable;
  logic [7:0]  loadAddr;
  logic [31:0] loadData;

  logic [31:0] model_mem [256];
  rsp_t        q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  instruction_fetch_responder dut (
    .clock      (clock),
    .reset      (reset),
    .reqValid   (reqValid),
    .reqReady   (reqReady),
    .reqAddr    (reqAddr),
    .rspValid   (rspValid),
    .rspReady   (rspReady),
    .rspInstr   (rspInstr),
    .rspAddr    (rspAddr),
    .rspFault   (rspFault),
    .loadEnable (loadEnable),
    .loadAddr   (loadAddr),
    .loadData   (loadData)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic drive(input logic rv, input logic [31:0] ra, input logic rr,
                       input logic le = 1'b0, input logic [7:0] la = 8'd0,
                       input logic [31:0] ld = 32'd0);
    reqValid   = rv;
    reqAddr    = ra;
    rspReady   = rr;
    loadEnable = le;
    loadAddr   = la;
    loadData   = ld;
  endtask

  // One clock: predict handshake, push expected on accept, pop on consume, compare after the edge.
  task automatic cycle(input string tag);
    logic exp_ready, acc, cons;
    rsp_t e;
    e = '0;
    #1;
    exp_ready = (q.size() == 0) || rspReady;
    chk({tag, ".reqReady"}, 32'(reqReady), 32'(exp_ready));
    acc  = reqValid && exp_ready;
    cons = (q.size() != 0) && rspReady;
    if (acc) begin
      e.addr  = reqAddr;
      e.fault = (reqAddr[1:0] != 2'b00) || (reqAddr >= 32'd1024);
      e.instr = e.fault ? 32'h0000_0013 : model_mem[reqAddr[9:2]];
    end
    if (loadEnable) model_mem[loadAddr] = loadData;
    @(posedge clock);
    #1;
    if (cons) void'(q.pop_front());
    if (acc) q.push_back(e);
    chk({tag, ".rspValid"}, 32'(rspValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".rspInstr"}, rspInstr, q[0].instr);
      chk({tag, ".rspAddr"},  rspAddr,  q[0].addr);
      chk({tag, ".rspFault"}, 32'(rspFault), 32'(q[0].fault));
    end
  endtask

  initial begin
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0);
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("rst.rspValid", 32'(rspValid), 32'd0);
    chk("rst.rspInstr", rspInstr, 32'd0);
    chk("rst.rspAddr",  rspAddr,  32'd0);
    chk("rst.rspFault", 32'(rspFault), 32'd0);
    chk("rst.reqReady", 32'(reqReady), 32'd1);
    reset = 1'b1;

    // Program load
    drive(1'b0, 32'd0, 1'b1, 1'b1, 8'd0,   32'h0050_0093); cycle("ld0");
    drive(1'b0, 32'd0, 1'b1, 1'b1, 8'd1,   32'h0010_0113); cycle("ld1");
    drive(1'b0, 32'd0, 1'b1, 1'b1, 8'd2,   32'hAAAA_AAAA); cycle("ld2");
    drive(1'b0, 32'd0, 1'b1, 1'b1, 8'd255, 32'h1234_5678); cycle("ld255");

    // Back-to-back fetches of words 0 and 1
    drive(1'b1, 32'd0, 1'b1); cycle("b2b0");
    drive(1'b1, 32'd4, 1'b1); cycle("b2b1");
    drive(1'b0, 32'd0, 1'b1); cycle("b2b_idle");

    // Backpressure on address 8
    drive(1'b1, 32'd8, 1'b0); cycle("bp_req");
    drive(1'b0, 32'd0, 1'b0); cycle("bp_hold1");
    cycle("bp_hold2");
    cycle("bp_hold3");
    drive(1'b0, 32'd0, 1'b1); cycle("bp_drain");
    cycle("bp_idle");

    // Faulting addresses: misaligned, just past the end, and near the top of the address space
    drive(1'b1, 32'h0000_0006, 1'b1); cycle("flt_mis");
    drive(1'b1, 32'h0000_0400, 1'b1); cycle("flt_oob");
    drive(1'b1, 32'hFFFF_FFFC, 1'b1); cycle("flt_top");
    drive(1'b0, 32'd0, 1'b1);         cycle("flt_idle");

    // Same-cycle load and fetch of word 2 returns old data
    drive(1'b1, 32'd8, 1'b1, 1'b1, 8'd2, 32'hBBBB_BBBB); cycle("rw_same");
    drive(1'b1, 32'd8, 1'b1);                           cycle("rw_next");
    drive(1'b0, 32'd0, 1'b1);                           cycle("rw_idle");

    // Last valid word
    drive(1'b1, 32'h0000_03FC, 1'b1); cycle("last");
    drive(1'b0, 32'd0, 1'b1);         cycle("last_idle");

    // Reset with a response pending
    drive(1'b1, 32'd0, 1'b0); cycle("mr_req");
    drive(1'b0, 32'd0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    chk("mr.rspValid", 32'(rspValid), 32'd0);
    chk("mr.rspInstr", rspInstr, 32'd0);
    chk("mr.rspAddr",  rspAddr,  32'd0);
    chk("mr.rspFault", 32'(rspFault), 32'd0);
    chk("mr.reqReady", 32'(reqReady), 32'd1);
    @(posedge clock);
    #1;
    chk("mr_hold.rspValid", 32'(rspValid), 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'd4, 1'b1);         cycle("mr_first");
    drive(1'b1, 32'h0000_03FC, 1'b1); cycle("mr_w255");
    drive(1'b1, 32'd8, 1'b1);         cycle("mr_w2");
    drive(1'b0, 32'd0, 1'b1);         cycle("mr_idle0");
    cycle("mr_idle1");

    chk("end.queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_responder.md
INSTRUCTION_FETCH_RESPONDER -- requirements
Module: instruction_fetch_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit instruction words.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h00000013, giving the instruction returned on a fault.
REQ-003 Port clock  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  is the asynchronous, active-low reset; reset=0 SHALL clear state immediately, with no clock edge needed.
REQ-005 Port reqValid  input  1  SHALL indicate a fetch request is present.
REQ-006 Port reqReady  output  1  SHALL indicate the block accepts a request this cycle.
REQ-007 Port reqAddr  input  32  SHALL carry the byte address (PC) of the request.
REQ-008 Port rspValid  output  1  SHALL indicate the response register holds a response.
REQ-009 Port rspReady  input  1  SHALL indicate the consumer accepts the response this cycle.
REQ-010 Port rspInstr  output  32  SHALL carry the fetched instruction word.
REQ-011 Port rspAddr  output  32  SHALL carry the reqAddr that produced the response.
REQ-012 Port rspFault  output  1  SHALL flag a misaligned or out-of-range request.
REQ-013 Port loadEnable  input  1  SHALL enable a program-load write this cycle.
REQ-014 Port loadAddr  input  $clog2(DEPTH)  SHALL carry the word index of the load write.
REQ-015 Port loadData  input  32  SHALL carry the word to be written.

Function
REQ-016 A request SHALL be accepted on a rising edge when reqValid=1 and reqReady=1.
REQ-017 reqReady SHALL equal (!rspValid || rspReady) combinationally, so the block sustains one accepted request per cycle.
REQ-018 Response latency SHALL be exactly one cycle: a request accepted at edge N SHALL appear with rspValid=1 after edge N.
REQ-019 The response register SHALL behave as a two-state machine. EMPTY goes to FULL on accept. FULL stays FULL on accept with rspReady=1. FULL goes to EMPTY on rspReady=1 without accept. FULL holds on rspReady=0.
REQ-020 While rspValid=1 and rspReady=0, rspInstr, rspAddr and rspFault SHALL remain stable.
REQ-021 The word index SHALL be reqAddr[$clog2(DEPTH)+1:2].
REQ-022 rspFault SHALL be 1 when reqAddr[1:0]!=0 or reqAddr >= 4*DEPTH.
REQ-023 When rspFault=1, rspInstr SHALL be NOP_WORD and the array SHALL NOT be indexed by the invalid address.
REQ-024 When loadEnable=1, the array SHALL write loadData at loadAddr on the rising edge, regardless of the handshake.
REQ-025 When a load and an accepted request target the same word in the same cycle, the response SHALL return the pre-write (old) contents.
REQ-026 reqAddr=4*DEPTH-4 SHALL be served normally; reqAddr=4*DEPTH SHALL fault. Address arithmetic SHALL NOT wrap.

Reset
REQ-027 During reset=0: rspValid=0, rspInstr=0, rspAddr=0, rspFault=0; reqReady SHALL therefore read 1.
REQ-028 Array contents SHALL NOT be reset; they SHALL persist across reset.
REQ-029 A request in flight when reset asserts SHALL be discarded, and no response for it SHALL appear after release.
REQ-030 The first acceptance after reset SHALL occur on the first rising edge with reset=1.

Structure
REQ-031 A shared package SHALL hold NOP_WORD, the default DEPTH and the fault-check function.
REQ-032 The storage array SHALL be one sub-module, instruction_rom_array: one synchronous write port and one read port.
REQ-033 The handshake and response register SHALL reside in instruction_fetch_responder.

Verification
REQ-034 Load word 0=32'h00500093 and word 1=32'h00100113, then request 0 and 4 back-to-back with rspReady=1 -> responses on consecutive cycles return those words, with rspAddr 0 and 4 and rspFault=0.
REQ-035 Request 8 with rspReady=0 for 3 cycles -> rspValid held, outputs stable, reqReady=0; rspReady=1 -> response consumed and reqReady=1.
REQ-036 Request 32'h00000006, then request 32'h00000400 (DEPTH=256) -> rspFault=1 and rspInstr=32'h00000013 for both.
REQ-037 Word 2=32'hAAAAAAAA; load word 2=32'hBBBBBBBB while requesting address 8 in the same cycle -> response 32'hAAAAAAAA; the next request to 8 -> 32'hBBBBBBBB.
REQ-038 Accept a request and assert reset=0 mid-cycle before the next edge -> rspValid=0 immediately; after release no stale response appears and previously loaded words are still readable.
REQ-039 Request 32'h000003FC -> served with rspFault=0 and the contents of word 255.
